// File: rtl/audio_pkg.sv
// Shared types and constants for the PDM audio recorder.
package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RECORD     = 2'd1,
        PLAY_FETCH = 2'd2,
        PLAY_WAIT  = 2'd3
    } rec_state_t;

endpackage

// File: rtl/sample_addr_counter.sv
// Sample RAM address counter: synchronous clear, increment, and a flag
// marking the last address of the RAM.
module sample_addr_counter #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] count,
    output logic              terminal
);

    // Clear has priority over increment so a restart never skips address 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + ADDR_W'(1);
        end
    end

    assign terminal = &count;

endmodule

// File: rtl/audio_record_ctrl.sv
// Top-level record/playback sequencer: streams Deserializer samples into the
// sample RAM while recording, and feeds them back to the serializer on playback.
module audio_record_ctrl
    import audio_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_rec_i,
    input  logic              start_play_i,
    input  logic              stop_i,
    output logic              des_enable_o,
    input  logic              des_done_i,
    input  logic [DATA_W-1:0] des_data_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              ser_enable_o,
    output logic [DATA_W-1:0] ser_data_o,
    input  logic              ser_done_i,
    output logic [ADDR_W:0]   rec_len_o,
    output logic [1:0]        state_o
);

    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LEN_FULL = LEN_ONE << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    rec_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic              addr_tc;
    logic              addr_clear;
    logic              addr_inc;
    logic              play_last;

    sample_addr_counter #(
        .ADDR_W(ADDR_W)
    ) u_addr (
        .clk      (clock_i),
        .rst      (reset_i),
        .clear    (addr_clear),
        .inc      (addr_inc),
        .count    (addr),
        .terminal (addr_tc)
    );

    assign play_last = ({1'b0, addr} == (rec_len_o - LEN_ONE));
    assign state_o   = state;

    // Address counter control: restart on any accepted start, advance after
    // each accepted write or each sample the serializer takes (except the last).
    always_comb begin
        addr_clear = 1'b0;
        addr_inc   = 1'b0;
        case (state)
            IDLE: begin
                addr_clear = start_rec_i | (start_play_i & (rec_len_o != '0));
            end
            RECORD: begin
                if (stop_i) begin
                    addr_inc = des_done_i;
                end else if (start_rec_i) begin
                    addr_clear = 1'b1;
                end else begin
                    addr_inc = des_done_i;
                end
            end
            PLAY_WAIT: begin
                addr_inc = ~stop_i & ser_enable_o & ser_done_i & ~play_last;
            end
            default: begin
                addr_clear = 1'b0;
                addr_inc   = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with all outputs registered; the write strobe defaults low
    // so a single des_done_i can only ever produce one write cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            des_enable_o <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            ser_enable_o <= 1'b0;
            ser_data_o   <= '0;
            rec_len_o    <= '0;
        end else begin
            mem_we_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_rec_i) begin
                        state        <= RECORD;
                        des_enable_o <= 1'b1;
                    end else if (start_play_i && (rec_len_o != '0)) begin
                        state      <= PLAY_FETCH;
                        mem_addr_o <= '0;
                    end
                end
                RECORD: begin
                    if (stop_i) begin
                        if (des_done_i) begin
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= addr;
                            mem_wdata_o <= des_data_i;
                        end
                        rec_len_o    <= {1'b0, addr} + (des_done_i ? LEN_ONE : '0);
                        state        <= IDLE;
                        des_enable_o <= 1'b0;
                    end else if (!start_rec_i && des_done_i) begin
                        mem_we_o    <= 1'b1;
                        mem_addr_o  <= addr;
                        mem_wdata_o <= des_data_i;
                        if (addr_tc) begin
                            rec_len_o    <= LEN_FULL;
                            state        <= IDLE;
                            des_enable_o <= 1'b0;
                        end
                    end
                end
                PLAY_FETCH: begin
                    if (stop_i) begin
                        state        <= IDLE;
                        ser_enable_o <= 1'b0;
                    end else begin
                        state <= PLAY_WAIT;
                    end
                end
                PLAY_WAIT: begin
                    if (stop_i) begin
                        state        <= IDLE;
                        ser_enable_o <= 1'b0;
                    end else if (!ser_enable_o) begin
                        ser_data_o   <= mem_rdata_i;
                        ser_enable_o <= 1'b1;
                    end else if (ser_done_i) begin
                        ser_enable_o <= 1'b0;
                        if (play_last) begin
                            state <= IDLE;
                        end else begin
                            state      <= PLAY_FETCH;
                            mem_addr_o <= addr + ADDR_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
